meter_display_ctrl: RTL and testbench



---
 rtl/meter_display_ctrl.sv | 118 +++++++++++
 tb/tb_meter_display_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/meter_display_ctrl.sv
// Display stage of the parking meter: filters the remaining-seconds count, converts it to BCD
// and derives the NORMAL/LOW/EXPIRED state, flash pattern, overtime and expiry pulse.
module meter_display_ctrl #(
    parameter int unsigned LOW_THRESH = 200,
    parameter int unsigned MAX_DISP   = 9999
) (
    input  logic        second_clk,
    input  logic        reset,
    input  logic [15:0] count_in,
    output logic [15:0] digits,
    output logic        blank,
    output logic [1:0]  state,
    output logic        expired,
    output logic        expire_pulse,
    output logic [13:0] overtime
);

    typedef enum logic [1:0] {
        StNormal  = 2'd0,
        StLow     = 2'd1,
        StExpired = 2'd2
    } disp_state_e;

    localparam logic [15:0] MaxDisp   = 16'(MAX_DISP);
    localparam logic [13:0] MaxOt     = 14'(MAX_DISP);
    localparam logic [15:0] LowThresh = 16'(LOW_THRESH);

    logic [15:0] s1_q, s2_q;
    logic [15:0] digits_q, digits_d;
    disp_state_e state_q, state_d, acc_state;
    logic [1:0]  ph_q, ph_d;
    logic [13:0] overtime_q, overtime_d;
    logic        pulse_q, pulse_d;
    logic        stable;
    logic [13:0] acc;

    // Shift-and-add-3 binary to BCD; values are pre-saturated to at most 9999.
    function automatic logic [15:0] to_bcd(input logic [13:0] bin);
        logic [29:0] sh;
        sh = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[14 + 4 * d +: 4] >= 4'd5) begin
                    sh[14 + 4 * d +: 4] = sh[14 + 4 * d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        return sh[29:14];
    endfunction

    always_ff @(posedge second_clk) begin
        if (reset) begin
            s1_q       <= 16'd0;
            s2_q       <= 16'd0;
            digits_q   <= 16'h0000;
            state_q    <= StExpired;
            ph_q       <= 2'd0;
            overtime_q <= 14'd0;
            pulse_q    <= 1'b0;
        end else begin
            s1_q       <= count_in;
            s2_q       <= s1_q;
            digits_q   <= digits_d;
            state_q    <= state_d;
            ph_q       <= ph_d;
            overtime_q <= overtime_d;
            pulse_q    <= pulse_d;
        end
    end

    always_comb begin
        stable = (s1_q == s2_q);
        acc    = (s2_q > MaxDisp) ? MaxOt : s2_q[13:0];

        if (acc == 14'd0) begin
            acc_state = StExpired;
        end else if ({2'b00, acc} < LowThresh) begin
            acc_state = StLow;
        end else begin
            acc_state = StNormal;
        end

        // An unstable sample holds the displayed value and state.
        digits_d = digits_q;
        state_d  = state_q;
        if (stable) begin
            digits_d = to_bcd(acc);
            state_d  = acc_state;
        end

        ph_d = (state_d != state_q) ? 2'd0 : ph_q + 2'd1;

        overtime_d = 14'd0;
        if (state_q == StExpired && state_d == StExpired) begin
            overtime_d = (overtime_q >= MaxOt) ? MaxOt : overtime_q + 14'd1;
        end

        pulse_d = (state_q != StExpired) && (state_d == StExpired);
    end

    always_comb begin
        blank = 1'b0;
        unique case (state_q)
            StNormal:  blank = 1'b0;
            StLow:     blank = ph_q[0];
            StExpired: blank = ph_q[1];
            default:   blank = 1'b0;
        endcase
        expired = (state_q == StExpired);
    end

    assign digits       = digits_q;
    assign state        = state_q;
    assign expire_pulse = pulse_q;
    assign overtime     = overtime_q;

endmodule

// File: tb/tb_meter_display_ctrl.sv
// Randomized bench for meter_display_ctrl: a behavioural model pushes expected outputs into a
// queue at each drive, and an independent monitor pops and compares after every clock edge.
module tb_meter_display_ctrl;

    typedef struct {
        logic [15:0] digits;
        logic        blank;
        logic [1:0]  state;
        logic        expired;
        logic        pulse;
        logic [13:0] overtime;
    } exp_t;

    logic        second_clk;
    logic        reset;
    logic [15:0] count_in;
    logic [15:0] digits;
    logic        blank;
    logic [1:0]  state;
    logic        expired;
    logic        expire_pulse;
    logic [13:0] overtime;

    meter_display_ctrl #(
        .LOW_THRESH(200),
        .MAX_DISP  (9999)
    ) dut (
        .second_clk  (second_clk),
        .reset       (reset),
        .count_in    (count_in),
        .digits      (digits),
        .blank       (blank),
        .state       (state),
        .expired     (expired),
        .expire_pulse(expire_pulse),
        .overtime    (overtime)
    );

    initial second_clk = 1'b0;
    always #5 second_clk = ~second_clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: last two sampled inputs, current state, seconds spent in it.
    int          hist[$];
    int          m_state;
    int          m_age;
    logic [15:0] m_digits;

    function automatic logic [15:0] dec_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t model_step(input logic r, input logic [15:0] c);
        exp_t e;
        int   prev;
        int   acc;
        if (r) begin
            hist     = '{0, 0};
            m_state  = 2;
            m_age    = 0;
            m_digits = 16'h0000;
            e.pulse  = 1'b0;
        end else begin
            prev = m_state;
            if (hist[0] == hist[1]) begin
                acc      = (hist[0] > 9999) ? 9999 : hist[0];
                m_digits = dec_bcd(acc);
                m_state  = (acc == 0) ? 2 : (acc < 200) ? 1 : 0;
            end
            e.pulse = (prev != 2) && (m_state == 2);
            m_age   = (m_state != prev) ? 0 : m_age + 1;
            void'(hist.pop_front());
            hist.push_back(int'(c));
        end
        e.digits   = m_digits;
        e.state    = 2'(m_state);
        e.expired  = (m_state == 2);
        e.blank    = (m_state == 1) ? ((m_age % 2) == 1) :
                     (m_state == 2) ? ((m_age % 4) >= 2) : 1'b0;
        e.overtime = (m_state == 2) ? 14'((m_age > 9999) ? 9999 : m_age) : 14'd0;
        return e;
    endfunction

    task automatic drive(input logic r, input logic [15:0] c);
        @(negedge second_clk);
        reset    = r;
        count_in = c;
        sb.push_back(model_step(r, c));
    endtask

    task automatic hold(input logic [15:0] c, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, c);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge second_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("digits", int'(digits), int'(e.digits));
                chk("state", int'(state), int'(e.state));
                chk("expired", int'(expired), int'(e.expired));
                chk("blank", int'(blank), int'(e.blank));
                chk("expire_pulse", int'(expire_pulse), int'(e.pulse));
                chk("overtime", int'(overtime), int'(e.overtime));
            end
        end
    end

    initial begin
        int          sel;
        logic [15:0] v;
        reset    = 1'b1;
        count_in = 16'd0;
        hist     = '{0, 0};
        m_state  = 2;
        m_age    = 0;
        m_digits = 16'h0000;

        drive(1'b1, 16'd0);
        drive(1'b1, 16'd0);
        hold(16'd1234, 6);
        hold(16'd150, 8);
        hold(16'd500, 4);
        hold(16'd0, 10);
        hold(16'd300, 6);
        hold(16'd40000, 4);
        hold(16'd200, 5);
        hold(16'd199, 5);
        hold(16'd1, 5);
        hold(16'd65535, 4);
        for (int i = 0; i < 10; i++) drive(1'b0, 16'(1000 + 37 * i));

        for (int s = 0; s < 80; s++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0:       v = 16'd0;
                1:       v = 16'd1;
                2:       v = 16'd199;
                3:       v = 16'd200;
                4:       v = 16'($urandom_range(0, 399));
                5:       v = 16'($urandom_range(9990, 10010));
                default: v = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) drive(1'b1, v);
            hold(v, int'($urandom_range(1, 7)));
        end

        hold(16'd0, 10005);
        hold(16'd150, 7);
        drive(1'b1, 16'd150);
        hold(16'd1234, 5);

        repeat (3) @(posedge second_clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
